// File: rtl/instr_loader_if.sv
// rtl/instr_loader_if.sv - byte stream in and instruction-memory write bus out of the loader
interface instr_loader_if #(
  parameter int ADDR_W = 8
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - serial program loader: length, big-endian words, XOR checksum
module instr_loader #(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           abort,
  instr_loader_if.slave  bus,
  output logic           busy,
  output logic           done,
  output logic           error
);
  typedef enum logic [2:0] {IDLE, LEN, DATA, WR, CHK} state_t;

  state_t            state, state_nxt;
  logic              ready_q, we_q;
  logic [ADDR_W-1:0] maddr_q, addr;
  logic [31:0]       wdata_q, word;
  logic [8:0]        remaining;
  logic [7:0]        chk;
  logic [1:0]        byte_idx;
  logic              xfer, ready_nxt, busy_nxt, we_nxt, done_nxt;

  assign xfer          = bus.in_valid && ready_q;
  assign bus.in_ready  = ready_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = maddr_q;
  assign bus.mem_wdata = wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Output registers are loaded from the next-state decode so they line up with the state.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = LEN;
      LEN:  if (abort) state_nxt = IDLE;
            else if (xfer) state_nxt = DATA;
      DATA: if (abort) state_nxt = IDLE;
            else if (xfer && byte_idx == 2'd3) state_nxt = WR;
      WR:   if (abort) state_nxt = IDLE;
            else state_nxt = (remaining == 9'd1) ? CHK : DATA;
      CHK:  if (abort || xfer) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    ready_nxt = (state_nxt == LEN) || (state_nxt == DATA) || (state_nxt == CHK);
    busy_nxt  = (state_nxt != IDLE);
    we_nxt    = (state_nxt == WR);
    done_nxt  = (state == CHK) && xfer && !abort;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q   <= 1'b0;
      we_q      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      maddr_q   <= '0;
      wdata_q   <= '0;
      addr      <= '0;
      word      <= '0;
      remaining <= '0;
      chk       <= '0;
      byte_idx  <= '0;
    end else begin
      ready_q <= ready_nxt;
      we_q    <= we_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      if (state == IDLE) begin
        if (start) error <= 1'b0;
      end else if (abort) begin
        error <= 1'b1;
      end else begin
        case (state)
          LEN: if (xfer) begin
            remaining <= (bus.in_data == 8'd0) ? 9'd256 : {1'b0, bus.in_data};
            addr      <= BASE_ADDR;
            chk       <= bus.in_data;
            byte_idx  <= 2'd0;
          end
          DATA: if (xfer) begin
            word     <= {word[23:0], bus.in_data};
            chk      <= chk ^ bus.in_data;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              maddr_q <= addr;
              wdata_q <= {word[23:0], bus.in_data};
            end
          end
          WR: begin
            addr      <= addr + ADDR_W'(1);
            remaining <= remaining - 9'd1;
          end
          CHK: if (xfer) error <= ((chk ^ bus.in_data) != 8'd0);
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_instr_loader.sv
// tb/tb_instr_loader.sv - self-checking bench for instr_loader
module tb_instr_loader;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       busy0, done0, error0, busy1, done1, error1;

  always #5 clk = ~clk;

  instr_loader_if #(.ADDR_W(8)) bus0 ();
  instr_loader_if #(.ADDR_W(8)) bus1 ();
  assign bus0.in_data  = in_data;
  assign bus0.in_valid = in_valid;
  assign bus1.in_data  = in_data;
  assign bus1.in_valid = in_valid;

  instr_loader #(.ADDR_W(8), .BASE_ADDR(8'h00)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .bus(bus0),
    .busy(busy0), .done(done0), .error(error0)
  );
  instr_loader #(.ADDR_W(8), .BASE_ADDR(8'hFE)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .bus(bus1),
    .busy(busy1), .done(done1), .error(error1)
  );

  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  logic        prev_we = 1'b0;
  logic [39:0] wq0[$];
  logic [39:0] wq1[$];
  logic [31:0] words[256];

  typedef struct {
    logic [7:0]  len;
    int          n;
    logic [31:0] w[3];
    logic [7:0]  bad;
    bit          gappy;
    logic        exp_err;
  } vec_t;
  vec_t vt[4];

  always @(negedge clk) begin
    if (bus0.mem_we) begin
      wq0.push_back({bus0.mem_addr, bus0.mem_wdata});
      checks++;
      if (prev_we) begin
        errors++;
        $display("FAIL we_back_to_back: mem_we high two cycles in a row at %0t", $time);
      end
    end
    if (bus1.mem_we) wq1.push_back({bus1.mem_addr, bus1.mem_wdata});
    prev_we = bus0.mem_we;
    if (done0) done_cnt++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gappy);
    int n;
    if (gappy) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus0.in_ready) begin
      n++;
      if (n > 40) begin
        errors++;
        $display("FAIL in_ready_timeout: in_ready still 0 after %0d cycles", n);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "stalled");
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_load(input logic [7:0] len, input int n, input bit gappy, input logic [7:0] bad);
    logic [7:0] c;
    logic [7:0] b;
    c = len;
    pulse_start();
    send_byte(len, gappy);
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 4; j++) begin
        b = words[i][31-8*j -: 8];
        c ^= b;
        send_byte(b, gappy);
      end
    end
    send_byte(c ^ bad, gappy);
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"},  busy0, 0);
    check({tag, "_done"},  done0, 0);
    check({tag, "_error"}, error0, 0);
    check({tag, "_ready"}, bus0.in_ready, 0);
    check({tag, "_we"},    bus0.mem_we, 0);
    check({tag, "_addr"},  bus0.mem_addr, 0);
    check({tag, "_wdata"}, bus0.mem_wdata, 0);
  endtask

  initial begin
    int d0;
    int nw;

    vt[0] = '{len: 8'h01, n: 1, w: '{32'h20080020, 32'h0, 32'h0}, bad: 8'h00, gappy: 1'b0, exp_err: 1'b0};
    vt[1] = '{len: 8'h01, n: 1, w: '{32'h20080020, 32'h0, 32'h0}, bad: 8'h03, gappy: 1'b0, exp_err: 1'b1};
    vt[2] = '{len: 8'h03, n: 3, w: '{32'h11111111, 32'h22222222, 32'h33333333}, bad: 8'h00, gappy: 1'b0, exp_err: 1'b0};
    vt[3] = '{len: 8'h02, n: 2, w: '{32'hDEADBEEF, 32'h01234567, 32'h0}, bad: 8'h00, gappy: 1'b1, exp_err: 1'b0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < vt[v].n; i++) words[i] = vt[v].w[i];
      wq0.delete();
      wq1.delete();
      d0 = done_cnt;
      run_load(vt[v].len, vt[v].n, vt[v].gappy, vt[v].bad);
      @(negedge clk);
      check($sformatf("v%0d_done", v), done0, 1);
      check($sformatf("v%0d_busy_at_done", v), busy0, 0);
      check($sformatf("v%0d_error", v), error0, vt[v].exp_err);
      @(posedge clk); #1;
      check($sformatf("v%0d_done_count", v), done_cnt - d0, 1);
      check($sformatf("v%0d_nwrites", v), wq0.size(), vt[v].n);
      check($sformatf("v%0d_nwrites_b", v), wq1.size(), vt[v].n);
      nw = (wq0.size() < vt[v].n) ? wq0.size() : vt[v].n;
      for (int i = 0; i < nw; i++)
        check($sformatf("v%0d_w%0d", v, i), wq0[i], {8'(i), vt[v].w[i]});
      nw = (wq1.size() < vt[v].n) ? wq1.size() : vt[v].n;
      for (int i = 0; i < nw; i++)
        check($sformatf("v%0d_base_w%0d", v, i), wq1[i], {8'hFE + 8'(i), vt[v].w[i]});
    end

    // L=0 means 256 words covering every address
    for (int i = 0; i < 256; i++) words[i] = {8'(i), ~8'(i), 8'(i) ^ 8'h5A, 8'hC3};
    wq0.delete();
    wq1.delete();
    d0 = done_cnt;
    run_load(8'h00, 256, 1'b0, 8'h00);
    @(negedge clk);
    check("full_done", done0, 1);
    check("full_error", error0, 0);
    @(posedge clk); #1;
    check("full_done_count", done_cnt - d0, 1);
    check("full_nwrites", wq0.size(), 256);
    nw = (wq0.size() < 256) ? wq0.size() : 256;
    for (int i = 0; i < nw; i++)
      if (wq0[i] !== {8'(i), words[i]}) check($sformatf("full_w%0d", i), wq0[i], {8'(i), words[i]});
    checks++;

    // leave error set, then a new start clears it and raises busy/in_ready next cycle
    words[0] = 32'h20080020;
    run_load(8'h01, 1, 1'b0, 8'h01);
    @(negedge clk);
    check("bad_error_set", error0, 1);
    @(posedge clk); #1;
    wq0.delete();
    d0 = done_cnt;
    words[0] = 32'hA5A5A5A5;
    words[1] = 32'h5A5A5A5A;
    pulse_start();
    @(negedge clk);
    check("start_clears_error", error0, 0);
    check("start_busy", busy0, 1);
    check("start_ready", bus0.in_ready, 1);
    @(posedge clk); #1;
    send_byte(8'h02, 1'b0);
    for (int j = 0; j < 4; j++) send_byte(words[0][31-8*j -: 8], 1'b0);
    send_byte(8'h5A, 1'b0);
    send_byte(8'h5A, 1'b0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort_busy", busy0, 0);
    check("abort_error", error0, 1);
    check("abort_done", done0, 0);
    check("abort_ready", bus0.in_ready, 0);
    repeat (3) @(posedge clk);
    #1;
    check("abort_nwrites", wq0.size(), 1);
    if (wq0.size() > 0) check("abort_w0", wq0[0], {8'h00, 32'hA5A5A5A5});
    check("abort_no_done", done_cnt - d0, 0);

    // reset in the middle of a word
    wq0.delete();
    d0 = done_cnt;
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    rst_n = 1'b0;
    #1;
    check_idle_zero("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("midreset_nwrites", wq0.size(), 0);
    check("midreset_no_done", done_cnt - d0, 0);
    check("midreset_error", error0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
